nibble_serial_addsub: RTL and testbench
=======================================

# nibble_serial_addsub

Multi-cycle add/subtract controller that computes a wide sum or difference by sequencing a single 4-bit add/sub slice, one nibble per clock, least-significant nibble first. It owns the operand shift registers, carry register and nibble counter. It presents a start/busy/done handshake to the surrounding datapath. It is the area-saving alternative to a full-width ripple adder wherever throughput of one result per NIBBLES+1 cycles is acceptable.

## Interface
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..8
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- op  in  1  0 = a+b, 1 = a-b; sampled with start
- a  in  W  operand A; sampled with start
- b  in  W  operand B; sampled with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse, result valid
- result  out  W  sum/difference; held until next accepted start
- cout  out  1  final carry-out; for subtract, 1 = no borrow
- ovf  out  1  signed two's-complement overflow (see Configuration)

## Operation
- Slice: s = x + y' + cin, where y' = y ^ {4{op}}. In the RUN state the slice takes x = a nibble i, y = b nibble i, and cin = the carry register.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - Latch a, b and op.
  - Set carry register = op, so subtract forms a + ~b + 1.
  - Clear the nibble index, clear result, go to RUN.
- IDLE/DONE with start=0: DONE -> IDLE after one cycle; IDLE holds.
- RUN, each cycle:
  - Write the slice sum into result nibble idx.
  - Carry register <= slice carry-out.
  - idx <= idx+1.
  - When idx = NIBBLES-1, go to DONE.
- cout = carry register after the last nibble.
- ovf = carry into MSB XOR carry out of MSB of the top nibble.
- start while in RUN is ignored. No queuing; the operation in flight is unaffected.
- Operands are used only from the internal registers. Changing a, b or op after acceptance has no effect.
- Arithmetic is modulo 2^W. There is no saturation.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, cout 0, ovf 0, idx 0, carry register 0.
- Reset asserted mid-RUN aborts immediately to the reset values. No done is produced.
- Start accepted at edge T0. busy is high from T0 through T(NIBBLES). At edge T(NIBBLES) the last nibble is written.
  - done is high for exactly the cycle following T(NIBBLES). busy is 0 in that cycle.
  - Latency start->done is NIBBLES+1 cycles: 5 for NIBBLES=4.
- result, cout and ovf are stable and valid from the done cycle until the edge that accepts the next start.
- start asserted in the done cycle is accepted: back-to-back throughput is one operation per NIBBLES+1 cycles. done deasserts as busy rises.
- Intermediate result nibbles are visible during RUN. They are not valid until done.

## Configuration
- OVF_DETECT_EN defined: the ovf register and its logic are built.
  - ovf updates on the last RUN cycle.
  - ovf is cleared on accepted start and on reset.
- OVF_DETECT_EN undefined: ovf is tied to constant 0 and no overflow logic is synthesised. All other behaviour is identical.

## Test plan
- Add, NIBBLES=4: a=0x1234, b=0x4321, op=0.
  - Expect result=0x5555, cout=0, ovf=0.
  - done exactly 5 cycles after the start edge; busy high for 4 cycles.
- Carry ripple across all nibbles: a=0xFFFF, b=0x0001, op=0.
  - Expect result=0x0000, cout=1, ovf=0.
- Subtract with borrow: a=0x0005, b=0x0007, op=1.
  - Expect result=0xFFFE, cout=0.
  - Then a=0x0007, b=0x0005 -> result=0x0002, cout=1.
- Signed overflow with OVF_DETECT_EN:
  - a=0x7FFF, b=0x0001, add -> result=0x8000, ovf=1.
  - a=0x8000, b=0x0001, sub -> result=0x7FFF, ovf=1.
  - Without the macro, ovf stays 0 in both cases.
- Handshake:
  - Pulse start again 2 cycles into RUN with different operands; it must be ignored and the first result is unchanged.
  - Assert start in the done cycle; it must be accepted, and the second result must arrive 5 cycles later.
- Reset mid-operation: drop rst_n 2 cycles after start.
  - Expect an immediate return to IDLE with all outputs 0 and no done pulse.
  - A subsequent 0x0001+0x0001 must complete normally with result=0x0002.

Source files
------------

// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: wide add/subtract built from one 4-bit slice, LS nibble first.
// Latency: NIBBLES RUN cycles after the accepting edge, then a one-cycle done pulse.
// No backpressure: start is taken only in IDLE/DONE and ignored while busy.
// Optional feature macro: OVF_DETECT_EN builds the signed-overflow flag (else ovf = 0).
module nibble_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic            w_last;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_op;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_result;

  logic [3:0]      w_y;
  logic [4:0]      w_sum;

  // The single slice: low nibbles of the shift registers plus the running carry.
  assign w_y   = r_b[3:0] ^ {4{r_op}};
  assign w_sum = {1'b0, r_a[3:0]} + {1'b0, w_y} + {4'b0000, r_carry};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state, start acceptance and last-nibble detection.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        if (r_idx == LAST_IDX) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand shift registers, carry, nibble index and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_op     <= op;
      r_carry  <= op;   // subtract becomes a + ~b + 1
      r_idx    <= '0;
      r_result <= '0;
    end else if (r_state == S_RUN) begin
      r_result[{r_idx, 2'b00} +: 4] <= w_sum[3:0];
      r_carry  <= w_sum[4];
      r_a      <= r_a >> 4;
      r_b      <= r_b >> 4;
      r_idx    <= r_idx + 1'b1;
    end
  end

`ifdef OVF_DETECT_EN
  logic       r_ovf;
  logic [3:0] w_low;

  // Carry into the top bit of the slice, needed only on the most significant nibble.
  assign w_low = {1'b0, r_a[2:0]} + {1'b0, w_y[2:0]} + {3'b000, r_carry};

  // Overflow flag: cleared on accept, captured when the top nibble is summed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ovf <= 1'b0;
    else if (w_accept) r_ovf <= 1'b0;
    else if (w_last)   r_ovf <= w_low[3] ^ w_sum[4];
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign cout   = r_carry;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub (NIBBLES=4), expected values worked by hand.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_nibble_serial_addsub;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        ovf;

  int n_checks;
  int n_fail;

`ifdef OVF_DETECT_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  nibble_serial_addsub #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge: presents start for one cycle and waits for done.
  // lat = falling edges until done is seen (counting the accept edge as 1).
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic iop,
                        output int lat, output int busy_cnt, output bit timeout);
    start = 1'b1; a = ia; b = ib; op = iop;
    lat = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; op = ~iop;
      end
      if (busy) busy_cnt++;
    end while (!done && lat < 20);
    timeout = !done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, result, cout, ovf} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b result=%h cout=%0b ovf=%0b, want all 0",
               busy, done, result, cout, ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  task automatic test_add;
    int lat, bc; bit to;
    run_op(16'h1234, 16'h4321, 1'b0, lat, bc, to);
    n_checks++;
    if (to || lat != 5) begin
      n_fail++; $display("FAIL add_latency: got %0d (timeout=%0b), want 5", lat, to);
    end
    n_checks++;
    if (bc != 4) begin
      n_fail++; $display("FAIL add_busy_cycles: got %0d, want 4", bc);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL add_busy_in_done: got %0b, want 0", busy);
    end
    n_checks++;
    if (result !== 16'h5555 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result: got %h c=%0b v=%0b, want 5555 c=0 v=0", result, cout, ovf);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || result !== 16'h5555) begin
      n_fail++;
      $display("FAIL add_hold: got done=%0b result=%h, want done=0 result=5555", done, result);
    end
  endtask

  task automatic test_carry_ripple;
    int lat, bc; bit to;
    run_op(16'hFFFF, 16'h0001, 1'b0, lat, bc, to);
    n_checks++;
    if (to || result !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ripple: got %h c=%0b v=%0b to=%0b, want 0000 c=1 v=0", result, cout, ovf, to);
    end
    @(negedge clk);
  endtask

  task automatic test_subtract;
    int lat, bc; bit to;
    run_op(16'h0005, 16'h0007, 1'b1, lat, bc, to);
    n_checks++;
    if (to || result !== 16'hFFFE || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: got %h c=%0b v=%0b to=%0b, want fffe c=0 v=0", result, cout, ovf, to);
    end
    @(negedge clk);
    run_op(16'h0007, 16'h0005, 1'b1, lat, bc, to);
    n_checks++;
    if (to || result !== 16'h0002 || cout !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_noborrow: got %h c=%0b v=%0b to=%0b, want 0002 c=1 v=0", result, cout, ovf, to);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    int lat, bc; bit to;
    run_op(16'h7FFF, 16'h0001, 1'b0, lat, bc, to);
    n_checks++;
    if (to || result !== 16'h8000 || cout !== 1'b0 || ovf !== OVF_ON) begin
      n_fail++;
      $display("FAIL ovf_add: got %h c=%0b v=%0b to=%0b, want 8000 c=0 v=%0b", result, cout, ovf, to, OVF_ON);
    end
    @(negedge clk);
    run_op(16'h8000, 16'h0001, 1'b1, lat, bc, to);
    n_checks++;
    if (to || result !== 16'h7FFF || cout !== 1'b1 || ovf !== OVF_ON) begin
      n_fail++;
      $display("FAIL ovf_sub: got %h c=%0b v=%0b to=%0b, want 7fff c=1 v=%0b", result, cout, ovf, to, OVF_ON);
    end
    // A following non-overflowing op must clear the flag.
    @(negedge clk);
    run_op(16'h0001, 16'h0002, 1'b0, lat, bc, to);
    n_checks++;
    if (to || result !== 16'h0003 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %h v=%0b to=%0b, want 0003 v=0", result, ovf, to);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat;
    start = 1'b1; a = 16'h1234; b = 16'h4321; op = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
      end else if (lat == 2) begin
        start = 1'b1; a = 16'hAAAA; b = 16'h1111; op = 1'b1;
      end else if (lat == 3) begin
        start = 1'b0;
      end
    end while (!done && lat < 20);
    n_checks++;
    if (!done || lat != 5 || result !== 16'h5555 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start: got lat=%0d result=%h c=%0b, want lat=5 result=5555 c=0", lat, result, cout);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL ignore_no_requeue: got busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc; bit to;
    run_op(16'h1111, 16'h2222, 1'b0, lat, bc, to);
    n_checks++;
    if (to || result !== 16'h3333) begin
      n_fail++; $display("FAIL b2b_first: got %h to=%0b, want 3333", result, to);
    end
    // Still in the done cycle: start here must be accepted.
    run_op(16'h00FF, 16'h0F01, 1'b0, lat, bc, to);
    n_checks++;
    if (to || lat != 5 || bc != 4) begin
      n_fail++; $display("FAIL b2b_timing: got lat=%0d busy=%0d to=%0b, want lat=5 busy=4", lat, bc, to);
    end
    n_checks++;
    if (result !== 16'h1000 || cout !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: got %h c=%0b, want 1000 c=0", result, cout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int lat, bc; bit to; bit saw_done;
    start = 1'b1; a = 16'h1234; b = 16'h4321; op = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, result, cout, ovf} !== 20'h0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy=%0b done=%0b result=%h cout=%0b ovf=%0b, want all 0",
               busy, done, result, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++; $display("FAIL midrun_no_done: got activity after abort=1, want 0");
    end
    run_op(16'h0001, 16'h0001, 1'b0, lat, bc, to);
    n_checks++;
    if (to || lat != 5 || result !== 16'h0002 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_op: got %h c=%0b lat=%0d to=%0b, want 0002 c=0 lat=5", result, cout, lat, to);
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add();
    test_carry_ripple();
    test_subtract();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
